// File: rtl/imm_extend_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imm_extend_pipe
//
// Pipelined immediate-extension stage for the 32-bit MIPS datapath. It sits
// between instruction decode and the ALU operand mux. A raw immediate and a
// 2-bit mode are extended combinationally, then captured into a registered
// OUT_W-bit operand. An opaque tag travels with each beat. Transfers use a
// valid/ready handshake, and back-pressure never loses data.
//
// Modes: 00 sign-extend, 01 zero-extend, 10 load-upper, 11 branch offset
//        (sign-extend, then shift left by SHIFT).
//
// Optional feature macro: IMM_EXT_SKID_EN
//   defined   : adds a skid register. in_ready comes straight from a flop
//               (skid empty), so out_ready has no combinational path to
//               in_ready. Capacity is 2 beats.
//   undefined : single output register.
//               in_ready = !out_valid || out_ready. Capacity is 1 beat.
//
// Parameters:
//   IN_W  (1..OUT_W)   raw immediate width
//   OUT_W              extended operand width
//   SHIFT (0..OUT_W-1) branch-offset left shift
//   TAG_W (>=1)        sideband tag width
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat present
//   in_ready   out  block can accept a beat
//   in_imm     in   raw immediate [IN_W]
//   in_mode    in   extension mode [2]
//   in_tag     in   sideband tag [TAG_W]
//   out_valid  out  result present
//   out_ready  in   consumer accepts result
//   out_data   out  extended operand [OUT_W], registered
//   out_tag    out  tag of the beat in out_data [TAG_W]
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Pure replicate/shift extension. The size casts also work when
    // OUT_W == IN_W: nothing is replicated, and the upper-mode shift is 0.
    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic signed [OUT_W-1:0] sx;
        logic        [OUT_W-1:0] zx;
        logic        [OUT_W-1:0] res;
        sx  = OUT_W'($signed(imm));
        zx  = OUT_W'(imm);
        res = sx;
        case (mode)
            2'b00: res = sx;
            2'b01: res = zx;
            2'b10: res = zx << (OUT_W - IN_W);
            2'b11: res = sx << SHIFT;
        endcase
        return res;
    endfunction

    logic [OUT_W-1:0] ext_w;
    logic             in_xfer;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

`ifdef IMM_EXT_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             out_free;
`endif

    assign ext_w = extend(in_imm, in_mode);

`ifdef IMM_EXT_SKID_EN
    assign in_ready = !skid_valid_q;
`else
    assign in_ready = !out_valid_q || out_ready;
`endif

    assign in_xfer = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
`ifdef IMM_EXT_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        // The output register can take a new beat this edge.
        out_free     = !out_valid_q || out_ready;
        if (out_free) begin
            // A full skid register holds the older beat, so it drains first.
            // in_ready is low in that case, so no input transfer can collide.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_valid_d  = 1'b1;
                out_data_d   = ext_w;
                out_tag_d    = in_tag;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_w;
            skid_tag_d   = in_tag;
        end
`else
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ext_w;
            out_tag_d   = in_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
`endif
    end

    // ---- output (and skid) register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
`ifdef IMM_EXT_SKID_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
`endif
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
`ifdef IMM_EXT_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
`timescale 1ns/1ps
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default-parameter DUT
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    // Small DUT: IN_W=8, OUT_W=16, SHIFT=1
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]  s_in_imm;
    logic [1:0]  s_in_mode;
    logic [4:0]  s_in_tag;
    logic [15:0] s_out_data;
    logic [4:0]  s_out_tag;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .SHIFT(1), .TAG_W(5)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_imm(s_in_imm),
        .in_mode(s_in_mode), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_tag(s_out_tag)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    exp_t e1, e2;

    int total = 0;
    int passed = 0;
    int outcnt = 0;
    int stream_on = 0;
    int drop_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor for the default DUT: occupancy-based handshake
    // checks every cycle, and in-order data/tag checks on each output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            check("occ_out_valid", out_valid, q.size() != 0);
`ifdef IMM_EXT_SKID_EN
            check("occ_in_ready", in_ready, q.size() < 2);
`else
            check("occ_in_ready", in_ready, (q.size() == 0) || out_ready);
`endif
            if (stream_on != 0 && !in_ready) drop_cnt++;
            if (out_valid && out_ready) begin
                outcnt++;
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat: got data 0x%0h tag %0d, expected no beat",
                             out_data, out_tag);
                end else begin
                    e1 = q.pop_front();
                    check("out_data", out_data, e1.d);
                    check("out_tag", out_tag, e1.t);
                end
            end
        end
    end

    // Scoreboard monitor for the small DUT.
    always @(negedge clk) begin
        if (rst_n && s_out_valid && s_out_ready) begin
            if (q2.size() == 0) begin
                total++;
                $display("FAIL s_unexpected_beat: got data 0x%0h, expected no beat", s_out_data);
            end else begin
                e2 = q2.pop_front();
                check("s_out_data", s_out_data, e2.d);
                check("s_out_tag", s_out_tag, e2.t);
            end
        end
    end

    // Call between a rising edge and the following falling edge. Returns
    // 1 ns after the accepting edge.
    task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag, input logic [31:0] exp);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        in_valid = 1'b1;
        in_imm = imm;
        in_mode = mode;
        in_tag = tag;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = in_ready;
            tries++;
            @(posedge clk);
            if (acc) q.push_back('{exp, tag});
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            $display("FAIL send_timeout tag %0d: in_ready stayed 0, expected 1", tag);
        end
    endtask

    task automatic send_s(input logic [7:0] imm, input logic [1:0] mode,
                          input logic [4:0] tag, input logic [15:0] exp);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        s_in_valid = 1'b1;
        s_in_imm = imm;
        s_in_mode = mode;
        s_in_tag = tag;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = s_in_ready;
            tries++;
            @(posedge clk);
            if (acc) q2.push_back('{{16'h0, exp}, tag});
            #1;
        end
        s_in_valid = 1'b0;
        if (!acc) begin
            total++;
            $display("FAIL s_send_timeout tag %0d: in_ready stayed 0, expected 1", tag);
        end
    endtask

    logic [15:0] v_imm [5] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF};
    logic [1:0]  v_mode[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [31:0] v_exp [5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000,
                               32'hFFFFFFFC, 32'h0001FFFC};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1);
    end

    initial begin
        time t0, t1;
        rst_n = 1'b0;
        in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_imm = '0; s_in_mode = '0; s_in_tag = '0; s_out_ready = 1'b1;

        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Directed mode vectors, each checked one cycle after acceptance
        for (int i = 0; i < 5; i++) begin
            send(v_imm[i], v_mode[i], 5'(i + 1), v_exp[i]);
            check("latency_valid", out_valid, 1);
            check("latency_data", out_data, v_exp[i]);
            @(posedge clk); #1;
        end

        // Back-to-back stream with out_ready held high
        stream_on = 1;
        drop_cnt = 0;
        outcnt = 0;
        t0 = $time;
        for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), 2'b01, 5'(i), 32'h00000100 + 32'(i));
        t1 = $time;
        stream_on = 0;
        @(posedge clk); #1;
        check("stream_cycles", (t1 - t0) / 10, 8);
        check("stream_out_count", outcnt, 8);
        check("stream_in_ready_drops", drop_cnt, 0);

        // Back-pressure: out_ready low for 3 cycles while 4 beats arrive
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(16'hFFF0 + 16'(i), 2'b00, 5'(8 + i), 32'hFFFFFFF0 + 32'(i));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("stall_drained", q.size(), 0);

        // Asynchronous reset with beats held
        out_ready = 1'b0;
        send(16'h1111, 2'b01, 5'd20, 32'h00001111);
`ifdef IMM_EXT_SKID_EN
        send(16'h2222, 2'b01, 5'd21, 32'h00002222);
`endif
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(16'h0005, 2'b00, 5'd22, 32'h00000005);
        check("post_rst_data", out_data, 32'h00000005);
        check("post_rst_tag", out_tag, 5'd22);
        @(posedge clk); #1;
        check("post_rst_no_stale", q.size(), 0);
        check("post_rst_idle", out_valid, 0);

        // Narrow configuration
        send_s(8'h80, 2'b11, 5'd1, 16'hFF00);
        check("s_latency_data", s_out_data, 16'hFF00);
        send_s(8'hAB, 2'b10, 5'd2, 16'hAB00);
        check("s_latency_data2", s_out_data, 16'hAB00);

        repeat (3) @(posedge clk);
        #1;
        check("final_q_empty", q.size(), 0);
        check("final_q2_empty", q2.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate-extension stage for the 32-bit MIPS datapath, placed between instruction decode and the ALU operand mux. It accepts a raw immediate field plus an extension mode and produces a registered OUT_W-bit operand. The modes are sign-extend, zero-extend, load-upper and branch-offset. A valid/ready handshake carries an opaque sideband tag alongside each operand, and back-pressure is supported without data loss.

## Interface
- IN_W, 16: immediate field width; legal range 1..OUT_W.
- OUT_W, 32: extended operand width.
- SHIFT, 2: left-shift amount applied in branch-offset mode; legal range 0..OUT_W-1.
- TAG_W, 5: sideband tag width (e.g. destination register); must be ≥1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  OUT_W  extended operand (registered).
- out_tag  output  TAG_W  tag of the beat in out_data.

## Operation
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready on a rising edge.
  - Output transfer occurs when out_valid && out_ready.
- Mode 00 (sign): every bit of out_data[OUT_W-1:IN_W] = in_imm[IN_W-1]; low IN_W bits = in_imm.
- Mode 01 (zero): out_data[OUT_W-1:IN_W] = 0; low IN_W bits = in_imm.
- Mode 10 (upper):
  - out_data[OUT_W-1:OUT_W-IN_W] = in_imm; remaining low bits = 0.
  - When OUT_W == IN_W, out_data = in_imm.
- Mode 11 (branch): sign-extend as mode 00, then shift left by SHIFT. Bits shifted past OUT_W-1 are discarded and vacated LSBs are 0.
- Extension is computed combinationally from the input beat and captured into the output register on transfer. No arithmetic other than replicate/shift.
- Output register behaviour:
  - out_data/out_tag hold steady while out_valid && !out_ready.
  - After an output transfer with no simultaneous input transfer, out_valid falls to 0. out_data/out_tag keep their last value.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Reset:
  - Reset values: out_valid=0, out_data=0, out_tag=0, in_ready=1.
  - Asserting rst_n mid-stream discards all held beats immediately (asynchronous).
  - The first transfer is possible on the first rising edge after rst_n deasserts.

## Timing
- Latency: a beat accepted at edge N appears on out_data with out_valid=1 after edge N, if the output stage is free.
- Throughput: one beat per cycle while out_ready stays 1, in both configurations.
- Simultaneous in and out transfer on a full output register replaces the output with the new beat in the same edge; out_valid stays 1.
- When out_ready is low and the output is held, behaviour depends on IMM_EXT_SKID_EN (see Configuration).

## Configuration
- Macro: IMM_EXT_SKID_EN.
- Defined:
  - A second (skid) register is added and in_ready is driven directly from a flop: in_ready = skid register empty.
  - An input transfer while out_valid && !out_ready lands in the skid register, and in_ready falls to 0 on the next cycle.
  - On the next output transfer the skid register moves into the output register, and in_ready returns to 1 the following cycle.
  - Capacity is 2 beats; there is no combinational path from out_ready to in_ready.
- Undefined:
  - No skid register; in_ready = !out_valid || out_ready (combinational).
  - Capacity is 1 beat.
- Data results, ordering and latency are identical in both builds.

## Test plan
- Default parameters, mode 00, in_imm=0x8001 → out_data=0xFFFF8001 one cycle later; mode 01, 0x8001 → 0x00008001.
- Mode 10, 0x1234 → 0x12340000. Mode 11: 0xFFFF → 0xFFFFFFFC, and 0x7FFF → 0x0001FFFC.
- Stream of 8 beats with out_ready held 1 → one beat per cycle, tags 0..7 emerge in order, and in_ready never drops.
- Stream of 4 beats with out_ready=0 for 3 cycles:
  - No loss or reordering.
  - With IMM_EXT_SKID_EN, in_ready=0 exactly while the skid register is full.
  - Without the macro, in_ready=0 whenever out_valid && !out_ready.
- Pull rst_n low with 2 beats held → out_valid=0, out_data=0 and in_ready=1 immediately. After release, a new beat (mode 00, 0x0005) → 0x00000005 with no stale beat emitted.
- IN_W=8, OUT_W=16, SHIFT=1, mode 11, in_imm=0x80 → out_data=0xFF00; mode 10, 0xAB → 0xAB00.
